// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the APB front-end of the pulse-counter block.
package apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        STROBE = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam logic [9:0] ADDR_CR = 10'h000;
    localparam logic [9:0] ADDR_SR = 10'h004;
    localparam int         WAIT_W  = 4;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational register-map decode; misaligned or unknown byte addresses are unmapped.
module apb_addr_decode
    import apb_bridge_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0] paddr,
    output logic              mapped,
    output logic              is_cr,
    output logic              is_sr
);

    // Exact match against the two word-aligned register addresses
    always_comb begin
        is_cr  = (paddr == ADDR_W'(ADDR_CR));
        is_sr  = (paddr == ADDR_W'(ADDR_SR));
        mapped = is_cr | is_sr;
    end

endmodule

// File: rtl/apb_counter_bridge.sv
// APB3 slave that turns setup/access transfers into single-cycle wr_en/rd_en
// strobes for the pulse counter and returns a registered read response.
module apb_counter_bridge
    import apb_bridge_pkg::*;
#(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              wr_en,
    output logic              rd_en,
    output logic [ADDR_W-1:0] addr,
    output logic [31:0]       wdata,
    input  logic [31:0]       rdata
);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(32'd1);

    state_t            state_r;
    state_t            state_s;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic              write_r;
    logic              err_r;

    logic              setup_s;
    logic              mapped_s;
    logic              is_cr_s;
    logic              is_sr_s;
    logic              decode_unused_s;
    logic              cur_write_s;
    logic              cur_err_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic              pready_s;
    logic              pslverr_s;
    logic [31:0]       prdata_s;

    apb_addr_decode #(.ADDR_W(ADDR_W)) u_decode (
        .paddr  (paddr),
        .mapped (mapped_s),
        .is_cr  (is_cr_s),
        .is_sr  (is_sr_s)
    );

    assign decode_unused_s = is_cr_s ^ is_sr_s;
    assign setup_s         = psel & ~penable;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; losing psel while waiting abandons the transfer silently
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (setup_s) begin
                    state_s = (WAIT_LOAD != '0) ? WAIT : STROBE;
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (!psel) begin
                    state_s = IDLE;
                end else if (wait_cnt_r <= WAIT_ONE) begin
                    state_s = STROBE;
                end else begin
                    state_s = WAIT;
                end
            end
            STROBE:  state_s = RESP;
            RESP:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Wait counter and transfer attribute capture at setup
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_r <= '0;
            write_r    <= 1'b0;
            err_r      <= 1'b0;
        end else if ((state_r == IDLE) && setup_s) begin
            wait_cnt_r <= WAIT_LOAD;
            write_r    <= pwrite;
            err_r      <= ~mapped_s;
        end else if ((state_r == WAIT) && (wait_cnt_r != '0)) begin
            wait_cnt_r <= wait_cnt_r - WAIT_ONE;
        end
    end

    // Output next-values derived from the upcoming state so every port is a flop.
    // With no wait states STROBE follows IDLE directly, so the live APB inputs
    // stand in for the not-yet-captured attributes.
    always_comb begin
        if (state_r == IDLE) begin
            cur_write_s = pwrite;
            cur_err_s   = ~mapped_s;
        end else begin
            cur_write_s = write_r;
            cur_err_s   = err_r;
        end
        wr_en_s   = (state_s == STROBE) & ~cur_err_s & cur_write_s;
        rd_en_s   = (state_s == STROBE) & ~cur_err_s & ~cur_write_s;
        pready_s  = (state_s == RESP);
        pslverr_s = pready_s & err_r;
        if (pready_s && !err_r && !write_r) begin
            prdata_s = rdata;
        end else begin
            prdata_s = 32'h0000_0000;
        end
    end

    // Registered outputs; addr/wdata hold until the next setup
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            rd_en   <= 1'b0;
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= 32'h0000_0000;
            addr    <= '0;
            wdata   <= 32'h0000_0000;
        end else begin
            wr_en   <= wr_en_s;
            rd_en   <= rd_en_s;
            pready  <= pready_s;
            pslverr <= pslverr_s;
            prdata  <= prdata_s;
            if ((state_r == IDLE) && setup_s) begin
                addr  <= paddr;
                wdata <= pwdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_counter_bridge.sv
// Bench for apb_counter_bridge: two instances (0 and 3 wait states) driven from a
// shared APB bus, a stand-in counter per instance, and a transaction-level reference.
module tb_apb_counter_bridge;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [9:0]  paddr;
    logic [31:0] pwdata;
    int          sel;

    logic        psel_w    [2];
    logic [31:0] prdata_w  [2];
    logic        pready_w  [2];
    logic        pslverr_w [2];
    logic        wr_en_w   [2];
    logic        rd_en_w   [2];
    logic [9:0]  addr_w    [2];
    logic [31:0] wdata_w   [2];
    logic [31:0] rdata_w   [2];

    logic [31:0] cnt_m [2];
    logic [31:0] cr_m  [2];
    logic [31:0] ref_cnt [2];
    logic [31:0] ref_cr  [2];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    assign psel_w[0] = psel && (sel == 0);
    assign psel_w[1] = psel && (sel == 1);

    apb_counter_bridge #(.WAIT_CYCLES(0), .ADDR_W(10)) dut0 (
        .clk(clk), .rst_n(rst_n), .psel(psel_w[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[0]), .pready(pready_w[0]),
        .pslverr(pslverr_w[0]), .wr_en(wr_en_w[0]), .rd_en(rd_en_w[0]),
        .addr(addr_w[0]), .wdata(wdata_w[0]), .rdata(rdata_w[0])
    );

    apb_counter_bridge #(.WAIT_CYCLES(3), .ADDR_W(10)) dut3 (
        .clk(clk), .rst_n(rst_n), .psel(psel_w[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata_w[1]), .pready(pready_w[1]),
        .pslverr(pslverr_w[1]), .wr_en(wr_en_w[1]), .rd_en(rd_en_w[1]),
        .addr(addr_w[1]), .wdata(wdata_w[1]), .rdata(rdata_w[1])
    );

    // Stand-in pulse counter: CR write with bit0 set counts one pulse, SR reads the count
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                cnt_m[i] <= 32'd0;
                cr_m[i]  <= 32'd0;
            end else if (wr_en_w[i] && addr_w[i] == 10'h000) begin
                cr_m[i] <= wdata_w[i];
                if (wdata_w[i][0]) cnt_m[i] <= cnt_m[i] + 32'd1;
            end
        end
    end
    assign rdata_w[0] = (addr_w[0] == 10'h004) ? cnt_m[0] : cr_m[0];
    assign rdata_w[1] = (addr_w[1] == 10'h004) ? cnt_m[1] : cr_m[1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_ref();
        for (int i = 0; i < 2; i++) begin
            ref_cnt[i] = 32'd0;
            ref_cr[i]  = 32'd0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_prdata", prdata_w[s], 32'd0);
            chk("reset_flags", 32'({pready_w[s], pslverr_w[s], wr_en_w[s], rd_en_w[s]}), 32'd0);
            chk("reset_addr", 32'(addr_w[s]), 32'd0);
            chk("reset_wdata", wdata_w[s], 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_ref();
    endtask

    // One APB transfer on instance s; called just after a rising edge.
    task automatic xfer(input int s, input bit wr, input logic [9:0] a, input logic [31:0] d,
                        input bit abort, input bit exp_err, input logic [31:0] exp_rd);
        int w, n_wr, n_rd, n_rdy, at_stb, at_rdy;
        logic [31:0] got_prd, got_wd;
        logic [9:0]  got_addr;
        logic        got_err, mapped, exp_wr, exp_rdn;
        w = (s == 0) ? 0 : 3;
        n_wr = 0; n_rd = 0; n_rdy = 0; at_stb = 0; at_rdy = 0;
        got_prd = 32'd0; got_wd = 32'd0; got_addr = 10'd0; got_err = 1'b0;
        sel = s; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(negedge clk);
        chk("quiet_in_setup", 32'({pready_w[s], wr_en_w[s], rd_en_w[s]}), 32'd0);
        @(posedge clk); #1;
        penable = 1'b1;
        for (int k = 1; k <= w + 2; k++) begin
            if (abort && k == 2) psel = 1'b0;
            @(negedge clk);
            if (wr_en_w[s]) begin n_wr++; at_stb = k; got_addr = addr_w[s]; got_wd = wdata_w[s]; end
            if (rd_en_w[s]) begin n_rd++; at_stb = k; got_addr = addr_w[s]; end
            if (pready_w[s]) begin n_rdy++; at_rdy = k; got_prd = prdata_w[s]; got_err = pslverr_w[s]; end
            @(posedge clk); #1;
        end
        psel = 1'b0; penable = 1'b0;
        mapped  = (a == 10'h000) || (a == 10'h004);
        exp_wr  = !abort && mapped && wr;
        exp_rdn = !abort && mapped && !wr;
        chk("wr_en_cycles", 32'(n_wr), 32'(exp_wr));
        chk("rd_en_cycles", 32'(n_rd), 32'(exp_rdn));
        if (exp_wr || exp_rdn) begin
            chk("strobe_cycle", 32'(at_stb), 32'(w + 1));
            chk("strobe_addr", 32'(got_addr), 32'(a));
        end
        if (exp_wr) chk("strobe_wdata", got_wd, d);
        chk("pready_cycles", 32'(n_rdy), abort ? 32'd0 : 32'd1);
        if (!abort) begin
            chk("pready_cycle", 32'(at_rdy), 32'(w + 2));
            chk("pslverr", 32'(got_err), 32'(exp_err));
            chk("prdata", got_prd, exp_rd);
        end
        if (!abort && mapped && wr && a == 10'h000) begin
            ref_cr[s] = d;
            if (d[0]) ref_cnt[s] = ref_cnt[s] + 32'd1;
        end
    endtask

    typedef struct {
        bit          rst;
        bit          wr;
        logic [9:0]  a;
        logic [31:0] d;
        bit          err;
        logic [31:0] prd;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int n_late;
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = 10'd0; pwdata = 32'd0; sel = 0;
        clear_ref();

        tbl[0]  = '{1'b1, 1'b1, 10'h000, 32'h1,        1'b0, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 10'h004, 32'h0,        1'b0, 32'h1};
        tbl[2]  = '{1'b1, 1'b1, 10'h000, 32'h1,        1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b1, 10'h000, 32'h1,        1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 10'h000, 32'h1,        1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 10'h004, 32'h0,        1'b0, 32'h3};
        tbl[6]  = '{1'b0, 1'b1, 10'h010, 32'h1,        1'b1, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 10'h006, 32'h0,        1'b1, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 10'h004, 32'h0,        1'b0, 32'h3};
        tbl[9]  = '{1'b0, 1'b1, 10'h000, 32'hA5A5_0000, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 10'h000, 32'h0,        1'b0, 32'hA5A5_0000};
        tbl[11] = '{1'b0, 1'b1, 10'h004, 32'h5,        1'b0, 32'h0};
        tbl[12] = '{1'b0, 1'b0, 10'h004, 32'h0,        1'b0, 32'h3};
        tbl[13] = '{1'b0, 1'b1, 10'h002, 32'h1,        1'b1, 32'h0};

        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].rst) do_reset();
            xfer(0, tbl[i].wr, tbl[i].a, tbl[i].d, 1'b0, tbl[i].err, tbl[i].prd);
        end

        // Three-wait-state instance: timing, abort during WAIT, then normal completion
        do_reset();
        xfer(1, 1'b0, 10'h004, 32'h0, 1'b0, 1'b0, 32'h0);
        xfer(1, 1'b1, 10'h000, 32'h1, 1'b0, 1'b0, 32'h0);
        xfer(1, 1'b0, 10'h004, 32'h0, 1'b0, 1'b0, 32'h1);
        xfer(1, 1'b1, 10'h000, 32'h1, 1'b1, 1'b0, 32'h0);
        xfer(1, 1'b0, 10'h004, 32'h0, 1'b0, 1'b0, 32'h1);
        xfer(1, 1'b0, 10'h006, 32'h0, 1'b0, 1'b1, 32'h0);

        // Reset while a write is waiting: strobe dropped, no response, latches cleared
        sel = 1; psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 10'h000; pwdata = 32'h1;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("inflight_reset_flags", 32'({pready_w[1], wr_en_w[1], rd_en_w[1]}), 32'd0);
        chk("inflight_reset_wdata", wdata_w[1], 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; psel = 1'b0; penable = 1'b0;
        clear_ref();
        n_late = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (wr_en_w[1] || rd_en_w[1] || pready_w[1]) n_late++;
        end
        @(posedge clk); #1;
        chk("inflight_reset_dropped", 32'(n_late), 32'd0);
        xfer(1, 1'b0, 10'h004, 32'h0, 1'b0, 1'b0, 32'h0);

        // Randomized transfers against the transaction-level reference
        for (int i = 0; i < 60; i++) begin
            int          s;
            bit          wr, ab, mp;
            logic [9:0]  a;
            logic [31:0] d, er;
            s  = $urandom_range(0, 1);
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            case ($urandom_range(0, 3))
                0:       a = 10'h000;
                1:       a = 10'h004;
                2:       a = 10'($urandom);
                default: a = 10'h004 | 10'($urandom_range(1, 3));
            endcase
            ab = (s == 1) && ($urandom_range(0, 7) == 0);
            mp = (a == 10'h000) || (a == 10'h004);
            if (wr || !mp)          er = 32'd0;
            else if (a == 10'h004)  er = ref_cnt[s];
            else                    er = ref_cr[s];
            xfer(s, wr, a, d, ab, !mp, er);
            if ($urandom_range(0, 3) == 0) begin
                penable = 1'b1;
                @(posedge clk); #1;
                penable = 1'b0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apb_counter_bridge.md
# apb_counter_bridge

APB3 slave front-end for the pulse-counter register block, sitting directly upstream of it. Converts APB setup/access transfers into the counter's single-cycle `wr_en`/`rd_en` strobes with `addr`/`wdata`, and captures the counter's combinational `rdata` into a registered `prdata`. Unmapped or misaligned accesses complete with `pslverr` and never reach the counter.

## Interface
- `WAIT_CYCLES`, 0: extra access-phase wait states inserted before the strobe; legal range 0..15.
- `ADDR_W`, 10: address width on both sides.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `psel`  in  1  APB select.
- `penable`  in  1  APB enable; high marks the access phase.
- `pwrite`  in  1  APB direction: 1 = write.
- `paddr`  in  ADDR_W  APB byte address.
- `pwdata`  in  32  APB write data.
- `prdata`  out  32  registered read data; valid only while `pready`=1.
- `pready`  out  1  transfer-complete indication.
- `pslverr`  out  1  error response; valid only while `pready`=1.
- `wr_en`  out  1  one-cycle write strobe to the counter.
- `rd_en`  out  1  one-cycle read strobe to the counter.
- `addr`  out  ADDR_W  latched register address.
- `wdata`  out  32  latched write data.
- `rdata`  in  32  counter read data, combinational from `addr`/`rd_en`.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset returns the FSM to IDLE and clears the wait counter.
- **Mapped addresses:** 10'h000 (CR) and 10'h004 (SR) only. Every other `paddr` is unmapped, including `paddr[1:0]`≠0.
- **IDLE**
  - `psel`=1 and `penable`=0 (setup) → latch `paddr`, `pwdata`, `pwrite`, error flag.
  - Go to WAIT if `WAIT_CYCLES`>0, else STROBE.
- **WAIT:** count down from `WAIT_CYCLES`; at 0 → STROBE.
- **STROBE** (exactly one cycle)
  - Mapped write → `wr_en`=1. Mapped read → `rd_en`=1.
  - On exit, `prdata`←`rdata` for reads, 0 for writes.
  - Unmapped → no strobe; `prdata`←0.
  - Always → RESP.
- **RESP** (exactly one cycle)
  - `pready`=1; `pslverr`=error flag.
  - Next state IDLE.
- `addr`/`wdata` hold their latched values until the next setup. `prdata`, `pready`, `pslverr` are 0 outside RESP.
- **Protocol violations:**
  - `psel` deasserted in WAIT → abort to IDLE; no strobe, no response.
  - Deassertion during STROBE still completes RESP.
  - `penable`=1 seen in IDLE (no setup) → ignored.
- A write to CR with `pwdata[0]`=1 yields exactly one `wr_en` cycle, hence exactly one counted pulse per APB write.

## Timing
- T0: setup cycle, sampled at end of T0.
- T1..T(WAIT_CYCLES): WAIT. `pready`=0.
- T(W+1): STROBE. `wr_en`/`rd_en` high for this cycle only. `rdata` is sampled at its closing edge.
- T(W+2): RESP. `pready`=1; the transfer ends at this edge.
- Access phase is W+2 cycles; a transfer is W+3 cycles including setup.
- Back-to-back: a setup in the cycle after RESP is accepted (IDLE samples it). Maximum throughput is one transfer per W+3 cycles.
- Strobes never overlap. `wr_en` and `rd_en` are never both 1.
- `rst_n` low at any edge → outputs 0 from the next cycle. An in-flight strobe is dropped with no response.

## Structure
- Package `apb_bridge_pkg`:
  - state enum {IDLE, WAIT, STROBE, RESP};
  - `ADDR_CR`=10'h000, `ADDR_SR`=10'h004;
  - a `WAIT_W`=4 localparam.
- One sub-module, `apb_addr_decode`: combinational; `paddr` → {mapped, is_cr, is_sr}. Reused by future register blocks.
- FSM, wait counter and capture registers stay in the top module.

## Test plan
- Reset: `rst_n`=0 for 2 cycles mid-idle → `prdata`, `pready`, `pslverr`, `wr_en`, `rd_en`, `addr`, `wdata` all 0.
- Write CR 32'h1, `WAIT_CYCLES`=0:
  - `wr_en`=1 for exactly 1 cycle in T1, with `addr`=10'h000 and `wdata`=32'h1;
  - `pready`=1 in T2, `pslverr`=0;
  - a follow-up SR read returns `prdata`=32'h1.
- Three back-to-back CR writes of 32'h1, then SR read → `prdata`=32'h3.
- Error response:
  - write to 10'h010 → no `wr_en`; `pready`=1 with `pslverr`=1.
  - read 10'h006 → no `rd_en`; `pslverr`=1, `prdata`=0.
- `WAIT_CYCLES`=3, read SR:
  - `pready` low for 4 access cycles, high in the 5th;
  - `rd_en` high only in the 4th.
- `psel` dropped during WAIT → no strobe and no `pready`; the next transfer completes normally.
